byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer.sv | 121 ++++++++++++
 tb/tb_byte_packer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_packer
// Brief    : Packs a stream of bytes into 16-bit words with ready/valid
//            handshakes on both sides; a flush pads out a held half word.
// Revision : 1.0 - initial release
// ============================================================================
module byte_packer #(
    parameter int         HI_FIRST = 1,
    parameter logic [7:0] PAD      = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [15:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_padded,
    output logic [15:0] word_count
);

    localparam logic [1:0] c_empty = 2'd0;
    localparam logic [1:0] c_half  = 2'd1;
    localparam logic [1:0] c_full  = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_first;
    logic [15:0] r_word;
    logic        r_padded;
    logic [15:0] r_count;

    logic [1:0]  w_state_nxt;
    logic [7:0]  w_first_nxt;
    logic [15:0] w_word_nxt;
    logic        w_padded_nxt;
    logic [15:0] w_count_nxt;
    logic        w_in_xfer;
    logic        w_out_xfer;
    logic        w_out_valid;
    logic        w_in_ready;

    // First-accepted byte lands in the upper half only when HI_FIRST is set.
    function automatic logic [15:0] f_pack(input logic [7:0] first, input logic [7:0] second);
        return (HI_FIRST != 0) ? {first, second} : {second, first};
    endfunction

    assign w_out_valid = (r_state == c_full);
    // In FULL a new byte can only enter when the held word leaves this cycle.
    assign w_in_ready  = (r_state != c_full) | out_ready;
    assign w_in_xfer   = in_valid & w_in_ready;
    assign w_out_xfer  = w_out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_empty;
            r_first  <= 8'h00;
            r_word   <= 16'h0000;
            r_padded <= 1'b0;
            r_count  <= 16'h0000;
        end else begin
            r_state  <= w_state_nxt;
            r_first  <= w_first_nxt;
            r_word   <= w_word_nxt;
            r_padded <= w_padded_nxt;
            r_count  <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_first_nxt  = r_first;
        w_word_nxt   = r_word;
        w_padded_nxt = r_padded;
        w_count_nxt  = w_out_xfer ? (r_count + 16'd1) : r_count;

        case (r_state)
            c_empty: begin
                if (w_in_xfer) begin
                    w_first_nxt = in_data;
                    w_state_nxt = c_half;
                end
            end
            c_half: begin
                // A byte arriving together with flush wins; flush is dropped.
                if (w_in_xfer) begin
                    w_word_nxt   = f_pack(r_first, in_data);
                    w_padded_nxt = 1'b0;
                    w_state_nxt  = c_full;
                end else if (flush) begin
                    w_word_nxt   = f_pack(r_first, PAD);
                    w_padded_nxt = 1'b1;
                    w_state_nxt  = c_full;
                end
            end
            c_full: begin
                if (w_out_xfer) begin
                    if (w_in_xfer) begin
                        w_first_nxt = in_data;
                        w_state_nxt = c_half;
                    end else begin
                        w_state_nxt = c_empty;
                    end
                end
            end
            default: begin
                w_state_nxt = c_empty;
            end
        endcase
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_word   = r_word;
    assign out_padded = r_padded;
    assign word_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_packer
// Brief    : Directed, table-driven bench for byte_packer (both byte orders).
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic [15:0] out_word;
    logic        out_valid;
    logic        out_padded;
    logic [15:0] word_count;

    logic        in_ready_lo;
    logic [15:0] out_word_lo;
    logic        out_valid_lo;
    logic        out_padded_lo;
    logic [15:0] word_count_lo;

    int n_total;
    int n_pass;

    byte_packer #(.HI_FIRST(1), .PAD(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_word   (out_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_padded (out_padded),
        .word_count (word_count)
    );

    byte_packer #(.HI_FIRST(0), .PAD(8'h00)) dut_lo (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready_lo),
        .flush      (flush),
        .out_word   (out_word_lo),
        .out_valid  (out_valid_lo),
        .out_ready  (out_ready),
        .out_padded (out_padded_lo),
        .word_count (word_count_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  din;
        logic        vld;
        logic        fl;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [15:0] e_hi;
        logic [15:0] e_lo;
        logic        e_pad;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic f, input logic r);
        in_data   = d;
        in_valid  = v;
        flush     = f;
        out_ready = r;
    endtask

    initial begin
        logic [15:0] exp_word;
        int          n_words;

        n_total = 0;
        n_pass  = 0;

        //            din    vld   fl    ordy  ir    ov    hi        lo        pad   cnt
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd0};
        vecs[1]  = '{8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd0};
        vecs[2]  = '{8'hBB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd0};
        vecs[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hAABB, 16'hBBAA, 1'b0, 16'd0};
        vecs[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[6]  = '{8'hCD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[7]  = '{8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd1};
        vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hCDAB, 16'hABCD, 1'b0, 16'd1};
        vecs[9]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd2};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd2};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'hFF00, 16'h00FF, 1'b1, 16'd2};
        vecs[12] = '{8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd3};
        vecs[13] = '{8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd3};
        vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1122, 16'h2211, 1'b0, 16'd3};
        vecs[15] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1122, 16'h2211, 1'b0, 16'd3};
        vecs[16] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1122, 16'h2211, 1'b0, 16'd3};
        vecs[17] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd4};
        vecs[18] = '{8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd4};
        vecs[19] = '{8'h34, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd4};
        vecs[20] = '{8'h56, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3412, 1'b0, 16'd4};
        vecs[21] = '{8'h56, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h3412, 1'b0, 16'd4};
        vecs[22] = '{8'h56, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h3412, 1'b0, 16'd4};
        vecs[23] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd5};
        vecs[24] = '{8'h78, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd5};
        vecs[25] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5678, 16'h7856, 1'b0, 16'd5};
        vecs[26] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'd6};

        // Reset state
        rst = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        #12;
        check("rst_ov",    {31'd0, out_valid}, 32'd0);
        check("rst_word",  {16'd0, out_word}, 32'h0000);
        check("rst_pad",   {31'd0, out_padded}, 32'd0);
        check("rst_cnt",   {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors: inputs held for one cycle, outputs sampled before the edge
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].din, vecs[i].vld, vecs[i].fl, vecs[i].ordy);
            #1;
            check($sformatf("v%0d_ir", i),  {31'd0, in_ready},   {31'd0, vecs[i].e_ir});
            check($sformatf("v%0d_ov", i),  {31'd0, out_valid},  {31'd0, vecs[i].e_ov});
            check($sformatf("v%0d_cnt", i), {16'd0, word_count}, {16'd0, vecs[i].e_cnt});
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_word", i),    {16'd0, out_word},    {16'd0, vecs[i].e_hi});
                check($sformatf("v%0d_word_lo", i), {16'd0, out_word_lo}, {16'd0, vecs[i].e_lo});
                check($sformatf("v%0d_pad", i),     {31'd0, out_padded},  {31'd0, vecs[i].e_pad});
            end
            @(negedge clk);
        end

        // Streaming 16 bytes with both sides always ready
        n_words = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(i[7:0], 1'b1, 1'b0, 1'b1);
            else        drive(8'h00, 1'b0, 1'b0, 1'b1);
            #1;
            if (i < 16) check($sformatf("stream%0d_ir", i), {31'd0, in_ready}, 32'd1);
            if (out_valid) begin
                exp_word = {n_words[6:0], 1'b0, n_words[6:0], 1'b1};
                check($sformatf("stream_word%0d", n_words), {16'd0, out_word}, {16'd0, exp_word});
                n_words++;
            end
            @(negedge clk);
        end
        check("stream_nwords", n_words, 32'd8);
        check("stream_cnt", {16'd0, word_count}, 32'd14);

        // Asynchronous reset discards an unaccepted full word
        drive(8'h01, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h02, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        check("full_ov_pre", {31'd0, out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("full_rst_ov",   {31'd0, out_valid}, 32'd0);
        check("full_rst_word", {16'd0, out_word}, 32'h0000);
        check("full_rst_cnt",  {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset mid-cycle while holding 8'h5A in HALF
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("pre_half_cnt", {16'd0, word_count}, 32'd0);
        drive(8'hAA, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h55, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h5A, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        check("half_cnt_pre", {16'd0, word_count}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("half_rst_ov",  {31'd0, out_valid}, 32'd0);
        check("half_rst_cnt", {16'd0, word_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(8'h01, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h02, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        drive(8'h00, 1'b0, 1'b0, 1'b1);
        #1;
        check("post_rst_ov",      {31'd0, out_valid}, 32'd1);
        check("post_rst_word",    {16'd0, out_word}, 32'h0102);
        check("post_rst_word_lo", {16'd0, out_word_lo}, 32'h0201);
        check("post_rst_pad",     {31'd0, out_padded}, 32'd0);
        @(negedge clk);
        check("post_rst_cnt",     {16'd0, word_count}, 32'd1);
        check("post_rst_ov_end",  {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
